// File: rtl/rat_hit_judge_if.sv
// rat_hit_judge_if: pushbutton/timer inputs and rat/score outputs of the whack-a-rat judge.
interface rat_hit_judge_if;
    logic [7:0] button;
    logic       sec_tick;
    logic       game_en;
    logic [7:0] rat_led;
    logic [7:0] score;
    logic       hit;
    logic       miss;

    modport master (output button, sec_tick, game_en, input rat_led, score, hit, miss);
    modport slave  (input button, sec_tick, game_en, output rat_led, score, hit, miss);
endinterface

// File: rtl/rat_hit_judge.sv
// rat_hit_judge: places the rat with a free-running LFSR, judges presses, keeps a 0..99 score.
// Optional macro RAT_MISS_PENALTY_EN: a wrong press also costs one point (floor 0).
module rat_hit_judge #(
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned FLASH_CYC  = 25000000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input logic            clk,
    input logic            reset,
    rat_hit_judge_if.slave bus
);
    localparam int unsigned   TW         = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned   FW         = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYC - 1);
    localparam logic [7:0]    SCORE_MAX  = 8'd99;

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, FLASH = 2'd2} state_t;

    state_t        state_r, state_s;
    logic [7:0]    btn_meta_r, btn_sync_r, btn_prev_r, press_s;
    logic [7:0]    lfsr_r;
    logic          lfsr_fb_s;
    logic [2:0]    pos_r, pos_s, new_pos_s;
    logic [TW-1:0] tick_cnt_r, tick_cnt_s;
    logic [FW-1:0] flash_cnt_r, flash_cnt_s;
    logic          en_prev_r;
    logic [7:0]    score_r, score_s;
    logic          hit_s, miss_s, hit_r, miss_r;
    logic [7:0]    led_s, rat_led_r;

    // A candidate equal to the current slot is bumped by one so the rat always moves.
    function automatic logic [2:0] pick_pos(input logic [2:0] cand, input logic [2:0] cur);
        pick_pos = (cand == cur) ? cur + 3'd1 : cand;
    endfunction

    // Two-flop synchronizer plus edge register for the raw buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_meta_r <= 8'd0;
            btn_sync_r <= 8'd0;
            btn_prev_r <= 8'd0;
        end else begin
            btn_meta_r <= bus.button;
            btn_sync_r <= btn_meta_r;
            btn_prev_r <= btn_sync_r;
        end
    end

    assign press_s   = btn_sync_r & ~btn_prev_r;
    assign lfsr_fb_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
    assign new_pos_s = pick_pos(lfsr_r[2:0], pos_r);

    // Free-running position LFSR, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_fb_s};
        end
    end

    // Next-state, counters, score and output decode.
    always_comb begin
        state_s     = state_r;
        pos_s       = pos_r;
        tick_cnt_s  = tick_cnt_r;
        flash_cnt_s = flash_cnt_r;
        score_s     = score_r;
        hit_s       = 1'b0;
        miss_s      = 1'b0;
        led_s       = 8'd0;
        case (state_r)
            IDLE: begin
                if (bus.game_en && !en_prev_r) begin
                    score_s    = 8'd0;
                    pos_s      = new_pos_s;
                    tick_cnt_s = {TW{1'b0}};
                    state_s    = SHOW;
                end else begin
                    state_s = IDLE;
                end
            end
            SHOW: begin
                if (!bus.game_en) begin
                    state_s = IDLE;
                end else if (press_s[pos_r]) begin
                    hit_s       = 1'b1;
                    score_s     = (score_r >= SCORE_MAX) ? SCORE_MAX : score_r + 8'd1;
                    flash_cnt_s = {FW{1'b0}};
                    state_s     = FLASH;
                end else begin
                    if (press_s != 8'd0) begin
                        miss_s = 1'b1;
`ifdef RAT_MISS_PENALTY_EN
                        score_s = (score_r == 8'd0) ? 8'd0 : score_r - 8'd1;
`else
                        score_s = score_r;
`endif
                    end else begin
                        miss_s = 1'b0;
                    end
                    if (bus.sec_tick) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            pos_s      = new_pos_s;
                            tick_cnt_s = {TW{1'b0}};
                        end else begin
                            tick_cnt_s = tick_cnt_r + TW'(1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                end
            end
            FLASH: begin
                if (!bus.game_en) begin
                    state_s = IDLE;
                end else if (flash_cnt_r == FLASH_LAST) begin
                    pos_s      = new_pos_s;
                    tick_cnt_s = {TW{1'b0}};
                    state_s    = SHOW;
                end else begin
                    flash_cnt_s = flash_cnt_r + FW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Decode from the next state so the registered LEDs line up with it.
        case (state_s)
            SHOW:    led_s = 8'd1 << pos_s;
            FLASH:   led_s = 8'hFF;
            default: led_s = 8'd0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            pos_r       <= 3'd0;
            tick_cnt_r  <= {TW{1'b0}};
            flash_cnt_r <= {FW{1'b0}};
            en_prev_r   <= 1'b0;
            score_r     <= 8'd0;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            rat_led_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            pos_r       <= pos_s;
            tick_cnt_r  <= tick_cnt_s;
            flash_cnt_r <= flash_cnt_s;
            en_prev_r   <= bus.game_en;
            score_r     <= score_s;
            hit_r       <= hit_s;
            miss_r      <= miss_s;
            rat_led_r   <= led_s;
        end
    end

    assign bus.rat_led = rat_led_r;
    assign bus.score   = score_r;
    assign bus.hit     = hit_r;
    assign bus.miss    = miss_r;
endmodule

// File: tb/tb_rat_hit_judge.sv
// tb_rat_hit_judge: scoreboard bench for rat_hit_judge (HOLD_TICKS=3, FLASH_CYC=8).
module tb_rat_hit_judge;
    localparam int FLASH = 8;

    typedef struct {
        bit         is_hit;
        logic [7:0] score;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    rat_hit_judge_if bus();

    rat_hit_judge #(.HOLD_TICKS(3), .FLASH_CYC(FLASH), .LFSR_SEED(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         cyc        = 0;
    logic [7:0] exp_score  = 8'd0;
    logic [7:0] model_lfsr = 8'hA5;
    logic [7:0] lfsr_used  = 8'hA5;
    logic       rst_seen   = 1'b1;
    logic [2:0] mon_pos    = 3'd0;
    logic [7:0] mon_prev   = 8'd0;

    function automatic int led_idx(input logic [7:0] v);
        led_idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) led_idx = i;
        end
    endfunction

    // Reference LFSR and cycle count, updated on the same edges the DUT uses.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rst_seen  <= ~reset;
        lfsr_used <= model_lfsr;
        if (!reset) model_lfsr <= 8'hA5;
        else        model_lfsr <= {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
    end

    // Monitor: pops hit/miss expectations and checks every new rat position.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] p;
        if (bus.hit || bus.miss) begin
            vectors++;
            if (bus.hit && bus.miss) begin
                miscompares++;
                $display("FAIL hit_miss_excl: both high at cycle %0d, required at most one", cyc);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b at cycle %0d, required none", bus.hit, bus.miss, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.hit !== e.is_hit || bus.score !== e.score || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL pulse: got hit=%0b score=%0d cycle=%0d, required hit=%0b score=%0d cycle=%0d",
                             bus.hit, bus.score, cyc, e.is_hit, e.score, e.cyc);
                end
            end
        end
        if (rst_seen) begin
            mon_pos  = 3'd0;
            mon_prev = bus.rat_led;
        end else begin
            if ($onehot(bus.rat_led) && bus.rat_led !== mon_prev) begin
                p = (lfsr_used[2:0] == mon_pos) ? mon_pos + 3'd1 : lfsr_used[2:0];
                vectors++;
                if (bus.rat_led !== (8'd1 << p)) begin
                    miscompares++;
                    $display("FAIL new_pos: got rat_led=%h, required %h (lfsr=%h old pos=%0d)",
                             bus.rat_led, 8'd1 << p, lfsr_used, mon_pos);
                end
                mon_pos = 3'(led_idx(bus.rat_led));
            end
            mon_prev = bus.rat_led;
        end
    end

    task automatic do_hit(input logic [7:0] score_after, input bit with_tick);
        int k;
        @(negedge clk);
        k = led_idx(bus.rat_led);
        bus.button = 8'd1 << k;
        sb.push_back('{1'b1, score_after, cyc + 3});
        repeat (2) @(negedge clk);
        if (with_tick) bus.sec_tick = 1'b1;
        @(negedge clk);
        bus.sec_tick = 1'b0;
        bus.button   = 8'd0;
    endtask

    task automatic wait_show();
        int n = 0;
        while (!$onehot(bus.rat_led) && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!$onehot(bus.rat_led)) begin
            miscompares++;
            $display("FAIL wait_show: rat_led=%h after %0d cycles, required one-hot", bus.rat_led, n);
        end
    endtask

    task automatic test_reset();
        bus.button = 8'd0; bus.sec_tick = 1'b0; bus.game_en = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (bus.rat_led !== 8'd0 || bus.score !== 8'd0 || bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: led=%h score=%0d hit=%0b miss=%0b, required all 0", bus.rat_led, bus.score, bus.hit, bus.miss);
        end
        vectors++;
        if (dut.lfsr_r !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset_lfsr: got %h, required a5", dut.lfsr_r);
        end
        @(negedge clk);
        vectors++;
        if (dut.lfsr_r !== 8'h4A || bus.rat_led !== 8'd0) begin
            miscompares++;
            $display("FAIL idle_step: lfsr=%h led=%h, required lfsr=4a led=00", dut.lfsr_r, bus.rat_led);
        end
    endtask

    task automatic test_hit();
        int n;
        logic [7:0] led_k;
        @(negedge clk);
        bus.game_en = 1'b1;
        @(negedge clk);
        wait_show();
        led_k      = bus.rat_led;
        bus.button = led_k;
        exp_score  = 8'd1;
        sb.push_back('{1'b1, 8'd1, cyc + 3});
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.rat_led !== 8'hFF) begin
            miscompares++;
            $display("FAIL flash_start: rat_led=%h, required ff", bus.rat_led);
        end
        n = 1;
        while (bus.rat_led === 8'hFF && n < 20) begin
            @(negedge clk);
            if (bus.rat_led === 8'hFF) n++;
        end
        vectors++;
        if (n != FLASH) begin
            miscompares++;
            $display("FAIL flash_len: %0d cycles, required %0d", n, FLASH);
        end
        vectors++;
        if (!$onehot(bus.rat_led) || bus.rat_led === led_k || bus.score !== 8'd1) begin
            miscompares++;
            $display("FAIL after_flash: led=%h score=%0d, required one-hot != %h and score 1", bus.rat_led, bus.score, led_k);
        end
        bus.button = 8'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL hit_pending: %0d expected pulses unseen, required 0", sb.size());
        end
    endtask

    task automatic test_miss();
        int k;
        logic [7:0] led0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            led0 = bus.rat_led;
            k = led_idx(led0);
`ifdef RAT_MISS_PENALTY_EN
            exp_score = (exp_score == 8'd0) ? 8'd0 : exp_score - 8'd1;
`endif
            bus.button = 8'd1 << ((k + 3) % 8);
            sb.push_back('{1'b0, exp_score, cyc + 3});
            repeat (3) @(negedge clk);
            bus.button = 8'd0;
            vectors++;
            if (bus.rat_led !== led0 || bus.score !== exp_score) begin
                miscompares++;
                $display("FAIL miss_state: led=%h score=%0d, required led=%h score=%0d", bus.rat_led, bus.score, led0, exp_score);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_tick();
        logic [7:0] old;
        old = bus.rat_led;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            bus.sec_tick = 1'b1;
            @(negedge clk);
            bus.sec_tick = 1'b0;
            vectors++;
            if (t < 3) begin
                if (bus.rat_led !== old) begin
                    miscompares++;
                    $display("FAIL tick_hold: tick %0d led=%h, required %h", t, bus.rat_led, old);
                end
            end else begin
                if (!$onehot(bus.rat_led) || bus.rat_led === old) begin
                    miscompares++;
                    $display("FAIL tick_move: led=%h, required one-hot differing from %h", bus.rat_led, old);
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        bus.game_en = 1'b0;
        repeat (2) @(negedge clk);
        bus.game_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.score !== 8'd0 || !$onehot(bus.rat_led)) begin
            miscompares++;
            $display("FAIL restart: score=%0d led=%h, required score 0 and one-hot", bus.score, bus.rat_led);
        end
        for (int i = 1; i <= 100; i++) begin
            do_hit((i > 99) ? 8'd99 : 8'(i), 1'b0);
            if (i < 100) wait_show();
        end
        bus.game_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.rat_led !== 8'd0 || bus.score !== 8'd99) begin
            miscompares++;
            $display("FAIL sat_idle: led=%h score=%0d, required led=00 score=99", bus.rat_led, bus.score);
        end
    endtask

    task automatic test_reset_mid_flash();
        @(negedge clk);
        bus.game_en = 1'b1;
        @(negedge clk);
        wait_show();
        do_hit(8'd1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if (bus.rat_led !== 8'd0 || bus.score !== 8'd0 || bus.hit !== 1'b0 || bus.miss !== 1'b0 || dut.lfsr_r !== 8'hA5) begin
            miscompares++;
            $display("FAIL mid_reset: led=%h score=%0d hit=%0b miss=%0b lfsr=%h, required zeros and lfsr a5",
                     bus.rat_led, bus.score, bus.hit, bus.miss, dut.lfsr_r);
        end
        @(negedge clk);
        wait_show();
        bus.sec_tick = 1'b1;
        @(negedge clk);
        bus.sec_tick = 1'b0;
        vectors++;
        if (dut.tick_cnt_r !== 2'd1) begin
            miscompares++;
            $display("FAIL tick_count: got %0d, required 1", dut.tick_cnt_r);
        end
        do_hit(8'd1, 1'b1);
        vectors++;
        if (dut.tick_cnt_r !== 2'd1 || bus.rat_led !== 8'hFF) begin
            miscompares++;
            $display("FAIL hit_with_tick: tick_cnt=%0d led=%h, required tick_cnt 1 led ff", dut.tick_cnt_r, bus.rat_led);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL end_pending: %0d expected pulses unseen, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_tick();
        test_saturate();
        test_reset_mid_flash();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rat_hit_judge.md
Name: rat_hit_judge

Overview:
- Game-logic stage for the whack-a-rat lab.
- Sits between the raw pushbuttons and the second/score display stage.
- Places the rat on one of 8 LEDs using a free-running LFSR and detects button hits.
- Keeps the score (0..99, binary) that the display stage renders on two 7-segment digits.

Parameters:
- HOLD_TICKS, 3: sec_tick pulses the rat stays lit before it moves unhit.
- FLASH_CYC, 25000000: clk cycles of hit flash (0.5 s at 50 MHz).
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- button  in  8  raw pushbuttons, 1 = pressed, asynchronous to clk.
- sec_tick  in  1  one-cycle pulse per second from the countdown timer.
- game_en  in  1  high while a round is running (countdown nonzero).
- rat_led  out  8  one-hot rat position; all zero when idle; all ones during flash.
- score  out  8  hit count, 0..99.
- hit  out  1  one-cycle pulse on a correct press.
- miss  out  1  one-cycle pulse on a wrong press.

Behaviour:
- Reset (reset==0 at posedge clk) values:
  - rat_led=0, score=0, hit=0, miss=0.
  - state=IDLE, lfsr=LFSR_SEED, pos=0, tick_cnt=0, flash_cnt=0.
  - Button sync regs cleared.
- Reset mid-operation aborts any state immediately; no partial score update.
- Input sync:
  - button passes through 2 flops, then an edge register; press = sync2 & ~prev.
  - A press is visible to the FSM 2 cycles after first sampled high.
  - hit/miss/score update on the 3rd posedge at which button is high.
  - Held buttons produce exactly one press.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk cycle in every state.
  - Never reaches 0.
- New position:
  - cand = lfsr[2:0].
  - If cand==pos, use (pos+1) mod 8.
  - Consecutive positions therefore always differ.
- FSM:
  - IDLE:
    - rat_led=0.
    - On game_en rising: score<=0, pick new pos, tick_cnt<=0, go SHOW.
  - SHOW:
    - rat_led = 1<<pos.
    - Press including bit pos: hit=1, score<=min(score+1,99), flash_cnt<=0, go FLASH. Other pressed bits that cycle are ignored; hit has priority.
    - Press with only other bits: miss=1, stay in SHOW.
    - sec_tick with no hit: tick_cnt+1. When tick_cnt reaches HOLD_TICKS-1, pick new pos and set tick_cnt<=0.
    - Hit and sec_tick in the same cycle: hit wins, tick discarded.
  - FLASH:
    - rat_led=8'hFF.
    - Presses and sec_tick ignored; no hit or miss.
    - When flash_cnt==FLASH_CYC-1: pick new pos, tick_cnt<=0, go SHOW.
  - game_en low in SHOW or FLASH: go IDLE next cycle; score held for display. This takes priority over a same-cycle press.
- Score saturates at 99; further hits still pulse hit.
- hit and miss are never asserted together.

Optional Feature:
- Macro: RAT_MISS_PENALTY_EN.
- Defined: a miss also sets score<=score-1, saturating at 0.
- Undefined: a miss only pulses miss; score unchanged.

Test Plan:
- Reset low for 2 cycles, then high, game_en=0 → rat_led=0, score=0, hit=miss=0; lfsr==8'hA5 on the first cycle after release.
- game_en 0→1 with pos=k; hold button[k] high for 10 cycles → exactly one hit pulse, 3 cycles after first sample; score=1; rat_led=8'hFF for FLASH_CYC (test value 8); then a new one-hot with pos≠k.
- In SHOW, press button[(k+3)%8] → miss pulse, score unchanged (defined: decremented, saturating at 0 from 0); rat_led unchanged.
- No presses, 3 sec_tick pulses (HOLD_TICKS=3) → position changes after the 3rd tick and differs from the previous one; no hit or miss.
- Preload 99 hits, press the correct button again → hit pulses, score stays 99; then drop game_en → IDLE, rat_led=0, score=99.
- Mid-FLASH, assert reset=0 for 1 cycle → all outputs 0 next cycle; button[k] and sec_tick asserted in the same cycle later → hit only, tick_cnt unchanged.
